// File: rtl/we_host_seq.sv
// Host command sequencer for WETOP: turns a 32-bit command stream into register-load
// strobes and trigger pulses, waits for completion, and returns readback/status words.
module we_host_seq #(
    parameter int unsigned TIMEOUT = 100000,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic [31:0] spi_config_msb,
    output logic [31:0] spi_config_lsb,
    output logic        spi_config_wr,
    output logic [31:0] spi_wav,
    output logic        spi_wav_wr,
    output logic        trigger_config,
    output logic        trigger_task,
    output logic        spi_out_rd,
    output logic        adc_out_rd,
    input  logic        done_spi,
    input  logic        done_task,
    input  logic [31:0] data_out_spi_msb,
    input  logic [31:0] data_out_spi_lsb,
    input  logic [31:0] data_out_adc
);

    localparam logic [2:0] OP_CFG_MSB   = 3'd0;
    localparam logic [2:0] OP_CFG_LSB   = 3'd1;
    localparam logic [2:0] OP_WAV       = 3'd2;
    localparam logic [2:0] OP_TRIG_CFG  = 3'd3;
    localparam logic [2:0] OP_TRIG_TASK = 3'd4;
    localparam logic [2:0] OP_RD_SPI    = 3'd5;
    localparam logic [2:0] OP_RD_ADC    = 3'd6;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_STROBE    = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_RD_PULSE  = 3'd4;
    localparam logic [2:0] ST_RD_WAIT   = 3'd5;
    localparam logic [2:0] ST_RSP       = 3'd6;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);
    localparam logic [31:0] RD_LAT_LAST  = 32'(RD_LAT - 1);

    logic [2:0]  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic        step_q, step_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] remaining_q, remaining_d;
    logic [31:0] payload_q, payload_d;
    logic [31:0] msb_stage_q, msb_stage_d;
    logic [31:0] cfg_msb_q, cfg_msb_d;
    logic [31:0] cfg_lsb_q, cfg_lsb_d;
    logic [31:0] wav_q, wav_d;
    logic [31:0] lsb_hold_q, lsb_hold_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        cfg_wr_q, cfg_wr_d;
    logic        wav_wr_q, wav_wr_d;
    logic        trig_cfg_q, trig_cfg_d;
    logic        trig_task_q, trig_task_d;
    logic        spi_rd_q, spi_rd_d;
    logic        adc_rd_q, adc_rd_d;
    logic        done_spi_q, done_spi_prev_q;
    logic        done_task_q, done_task_prev_q;

    logic cmd_accept;
    logic done_rise;

    assign cmd_accept = cmd_valid && cmd_ready_q;
    // The first WAIT_DONE cycle is skipped (cnt_q == 0) so the baseline level is the
    // one sampled while WETOP sees the trigger; a level already high never counts.
    assign done_rise  = (op_q == OP_TRIG_CFG) ? (done_spi_q && !done_spi_prev_q)
                                              : (done_task_q && !done_task_prev_q);

    always_comb begin
        // NOTE: every next-state value gets a default first so no latch is inferred.
        state_d     = state_q;
        op_d        = op_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        remaining_d = remaining_q;
        payload_d   = payload_q;
        msb_stage_d = msb_stage_q;
        cfg_msb_d   = cfg_msb_q;
        cfg_lsb_d   = cfg_lsb_q;
        wav_d       = wav_q;
        lsb_hold_d  = lsb_hold_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_valid_d = rsp_valid_q;
        cfg_wr_d    = 1'b0;
        wav_wr_d    = 1'b0;
        trig_cfg_d  = 1'b0;
        trig_task_d = 1'b0;
        spi_rd_d    = 1'b0;
        adc_rd_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    op_d      = cmd_op;
                    payload_d = cmd_data;
                    step_d    = 1'b0;
                    case (cmd_op)
                        OP_CFG_MSB:               msb_stage_d = cmd_data;
                        OP_CFG_LSB, OP_WAV:       state_d = ST_LOAD;
                        OP_TRIG_CFG, OP_TRIG_TASK: state_d = ST_STROBE;
                        OP_RD_SPI:                state_d = ST_RD_PULSE;
                        OP_RD_ADC: begin
                            state_d     = ST_RD_PULSE;
                            remaining_d = (cmd_data[15:0] == 16'd0) ? 16'd1 : cmd_data[15:0];
                        end
                        default: begin
                            state_d    = ST_RSP;
                            rsp_data_d = 32'hBAD0_0007;
                            rsp_err_d  = 1'b1;
                        end
                    endcase
                end
            end
            ST_LOAD: begin
                state_d = ST_STROBE;
                if (op_q == OP_CFG_LSB) begin
                    cfg_msb_d = msb_stage_q;
                    cfg_lsb_d = payload_q;
                end else begin
                    wav_d = payload_q;
                end
            end
            ST_STROBE: begin
                if (!step_q) begin
                    step_d = 1'b1;
                    case (op_q)
                        OP_CFG_LSB:  cfg_wr_d    = 1'b1;
                        OP_WAV:      wav_wr_d    = 1'b1;
                        OP_TRIG_CFG: trig_cfg_d  = 1'b1;
                        default:     trig_task_d = 1'b1;
                    endcase
                end else begin
                    step_d = 1'b0;
                    if (op_q == OP_TRIG_CFG || op_q == OP_TRIG_TASK) begin
                        state_d = ST_WAIT_DONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (cnt_q != 32'd0 && done_rise) begin
                    state_d    = ST_RSP;
                    rsp_data_d = {29'd0, op_q};
                    rsp_err_d  = 1'b0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d    = ST_RSP;
                    rsp_data_d = {16'hDEAD, 13'd0, op_q};
                    rsp_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_RD_PULSE: begin
                state_d = ST_RD_WAIT;
                cnt_d   = '0;
                if (op_q == OP_RD_SPI) spi_rd_d = 1'b1;
                else                   adc_rd_d = 1'b1;
            end
            ST_RD_WAIT: begin
                if (cnt_q == RD_LAT_LAST) begin
                    state_d   = ST_RSP;
                    step_d    = 1'b0;
                    rsp_err_d = 1'b0;
                    if (op_q == OP_RD_SPI) begin
                        rsp_data_d = data_out_spi_msb;
                        lsb_hold_d = data_out_spi_lsb;
                    end else begin
                        rsp_data_d = data_out_adc;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_RSP: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (op_q == OP_RD_SPI && !step_q) begin
                        step_d     = 1'b1;
                        rsp_data_d = lsb_hold_q;
                    end else if (op_q == OP_RD_ADC && remaining_q > 16'd1) begin
                        remaining_d = remaining_q - 16'd1;
                        state_d     = ST_RD_PULSE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            op_q             <= '0;
            step_q           <= 1'b0;
            cnt_q            <= '0;
            remaining_q      <= '0;
            payload_q        <= '0;
            msb_stage_q      <= '0;
            cfg_msb_q        <= '0;
            cfg_lsb_q        <= '0;
            wav_q            <= '0;
            lsb_hold_q       <= '0;
            rsp_data_q       <= '0;
            rsp_err_q        <= 1'b0;
            rsp_valid_q      <= 1'b0;
            cmd_ready_q      <= 1'b0;
            cfg_wr_q         <= 1'b0;
            wav_wr_q         <= 1'b0;
            trig_cfg_q       <= 1'b0;
            trig_task_q      <= 1'b0;
            spi_rd_q         <= 1'b0;
            adc_rd_q         <= 1'b0;
            done_spi_q       <= 1'b0;
            done_spi_prev_q  <= 1'b0;
            done_task_q      <= 1'b0;
            done_task_prev_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            step_q           <= step_d;
            cnt_q            <= cnt_d;
            remaining_q      <= remaining_d;
            payload_q        <= payload_d;
            msb_stage_q      <= msb_stage_d;
            cfg_msb_q        <= cfg_msb_d;
            cfg_lsb_q        <= cfg_lsb_d;
            wav_q            <= wav_d;
            lsb_hold_q       <= lsb_hold_d;
            rsp_data_q       <= rsp_data_d;
            rsp_err_q        <= rsp_err_d;
            rsp_valid_q      <= rsp_valid_d;
            cmd_ready_q      <= cmd_ready_d;
            cfg_wr_q         <= cfg_wr_d;
            wav_wr_q         <= wav_wr_d;
            trig_cfg_q       <= trig_cfg_d;
            trig_task_q      <= trig_task_d;
            spi_rd_q         <= spi_rd_d;
            adc_rd_q         <= adc_rd_d;
            done_spi_q       <= done_spi;
            done_spi_prev_q  <= done_spi_q;
            done_task_q      <= done_task;
            done_task_prev_q <= done_task_q;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign busy           = (state_q != ST_IDLE);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_err        = rsp_err_q;
    assign spi_config_msb = cfg_msb_q;
    assign spi_config_lsb = cfg_lsb_q;
    assign spi_config_wr  = cfg_wr_q;
    assign spi_wav        = wav_q;
    assign spi_wav_wr     = wav_wr_q;
    assign trigger_config = trig_cfg_q;
    assign trigger_task   = trig_task_q;
    assign spi_out_rd     = spi_rd_q;
    assign adc_out_rd     = adc_rd_q;

endmodule

// File: tb/tb_we_host_seq.sv
// Directed bench for we_host_seq: config/waveform loads, triggers with done and timeout,
// readback under back-pressure, opcode 7 and reset in the middle of an operation.
module tb_we_host_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err, busy;
    logic [31:0] spi_config_msb, spi_config_lsb, spi_wav;
    logic        spi_config_wr, spi_wav_wr;
    logic        trigger_config, trigger_task, spi_out_rd, adc_out_rd;
    logic        done_spi, done_task;
    logic [31:0] data_out_spi_msb, data_out_spi_lsb;
    logic [31:0] data_out_adc = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;
    int adc_idx  = 0;
    int wav_pulses = 0;
    logic [31:0] wav_exp = 32'd0;

    we_host_seq #(.TIMEOUT(50), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy),
        .spi_config_msb(spi_config_msb), .spi_config_lsb(spi_config_lsb),
        .spi_config_wr(spi_config_wr), .spi_wav(spi_wav), .spi_wav_wr(spi_wav_wr),
        .trigger_config(trigger_config), .trigger_task(trigger_task),
        .spi_out_rd(spi_out_rd), .adc_out_rd(adc_out_rd),
        .done_spi(done_spi), .done_task(done_task),
        .data_out_spi_msb(data_out_spi_msb), .data_out_spi_lsb(data_out_spi_lsb),
        .data_out_adc(data_out_adc)
    );

    always #5 clk = ~clk;

    // ADC stub: each read strobe presents the next word 0xA0, 0xA1, ...
    always @(posedge adc_out_rd) begin
        data_out_adc <= 32'hA0 + 32'(adc_idx);
        adc_idx      <= adc_idx + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every waveform strobe must carry the next expected word while cmd_ready is low;
    // any strobe cycle must have exactly one strobe high.
    always @(negedge clk) begin
        if (spi_wav_wr) begin
            check("wav_word", spi_wav, wav_exp);
            check("wav_rdy_low", {31'd0, cmd_ready}, 32'd0);
            wav_exp    <= wav_exp + 32'd1;
            wav_pulses <= wav_pulses + 1;
        end
        if (spi_config_wr | spi_wav_wr | trigger_config | trigger_task | spi_out_rd | adc_out_rd)
            check("strobe_onehot",
                  32'($countones({spi_config_wr, spi_wav_wr, trigger_config,
                                  trigger_task, spi_out_rd, adc_out_rd})), 32'd1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check({"ready_", tag}, {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] data);
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        wait_ready("send");
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic [31:0] exp_data,
                           input logic exp_err, input int stall);
        int n = 0;
        logic [31:0] held;
        logic stable = 1'b1;
        while (rsp_valid !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_data"}, rsp_data, exp_data);
        check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        held = rsp_data;
        for (int i = 0; i < stall; i++) begin
            step();
            if (rsp_valid !== 1'b1 || rsp_data !== held) stable = 1'b0;
        end
        if (stall > 0) check({tag, "_stall"}, {31'd0, stable}, 32'd1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic no_rsp_for(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (rsp_valid === 1'b1) seen++;
            step();
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 32'd0; rsp_ready = 1'b0;
        done_spi = 1'b0; done_task = 1'b0;
        data_out_spi_msb = 32'h1111_0000;
        data_out_spi_lsb = 32'h2222_FFFF;
        repeat (3) step();

        // Reset state
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_cfg_msb", spi_config_msb, 32'd0);
        rst = 1'b1;
        check("release_rdy0", {31'd0, cmd_ready}, 32'd0);
        step();
        check("release_rdy1", {31'd0, cmd_ready}, 32'd1);

        // Config load: T is the CFG_LSB acceptance edge
        send(3'd0, 32'h1234_5678);
        send(3'd1, 32'h9ABC_DEF0);
        check("cfg_t0_rdy", {31'd0, cmd_ready}, 32'd0);
        step();
        check("cfg_t1_lsb", spi_config_lsb, 32'h9ABC_DEF0);
        check("cfg_t1_msb", spi_config_msb, 32'h1234_5678);
        check("cfg_t1_wr", {31'd0, spi_config_wr}, 32'd0);
        step();
        check("cfg_t2_wr", {31'd0, spi_config_wr}, 32'd1);
        check("cfg_t2_lsb", spi_config_lsb, 32'h9ABC_DEF0);
        step();
        check("cfg_t3_wr", {31'd0, spi_config_wr}, 32'd0);
        check("cfg_t3_rdy", {31'd0, cmd_ready}, 32'd1);
        check("cfg_t3_msb", spi_config_msb, 32'h1234_5678);

        // Waveform load, cmd_valid held across all eight words
        cmd_op = 3'd2;
        cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cmd_data = 32'(i);
            wait_ready("wav");
            step();
        end
        cmd_valid = 1'b0;
        repeat (5) step();
        check("wav_pulses", 32'(wav_pulses), 32'd8);
        check("wav_hold", spi_wav, 32'd7);

        // Config trigger, done_spi rises 40 cycles after the pulse
        send(3'd3, 32'd0);
        check("tcfg_t0", {31'd0, trigger_config}, 32'd0);
        step();
        check("tcfg_t1", {31'd0, trigger_config}, 32'd1);
        step();
        check("tcfg_t2", {31'd0, trigger_config}, 32'd0);
        no_rsp_for("tcfg_early", 40);
        done_spi = 1'b1;
        no_rsp_for("tcfg_latency", 2);
        get_rsp("tcfg_rsp", 32'h0000_0003, 1'b0, 0);

        // done_spi already high: no completion, so the wait times out
        send(3'd3, 32'd0);
        get_rsp("tcfg_held", 32'hDEAD_0003, 1'b1, 0);
        done_spi = 1'b0;

        // Task timeout: no response during the trigger and the 50 wait cycles
        send(3'd4, 32'd0);
        no_rsp_for("ttask_early", 51);
        get_rsp("ttask_to", 32'hDEAD_0004, 1'b1, 0);

        // done_task rises on the terminal wait cycle: done wins
        send(3'd4, 32'd0);
        repeat (50) step();
        done_task = 1'b1;
        get_rsp("ttask_term", 32'h0000_0004, 1'b0, 0);
        done_task = 1'b0;

        // ADC readback, N=3, rsp_ready held low 5 cycles per word
        send(3'd6, 32'd3);
        check("adc_t0_rd", {31'd0, adc_out_rd}, 32'd0);
        step();
        check("adc_t1_rd", {31'd0, adc_out_rd}, 32'd1);
        step();
        check("adc_t2_rd", {31'd0, adc_out_rd}, 32'd0);
        check("adc_t2_vld", {31'd0, rsp_valid}, 32'd0);
        step();
        check("adc_t3_vld", {31'd0, rsp_valid}, 32'd1);
        get_rsp("adc_w0", 32'h0000_00A0, 1'b0, 5);
        get_rsp("adc_w1", 32'h0000_00A1, 1'b0, 5);
        get_rsp("adc_w2", 32'h0000_00A2, 1'b0, 5);
        wait_ready("adc_done");
        check("adc_pulses", 32'(adc_idx), 32'd3);

        // SPI readback: MSB then LSB
        send(3'd5, 32'd0);
        get_rsp("spi_msb", 32'h1111_0000, 1'b0, 2);
        get_rsp("spi_lsb", 32'h2222_FFFF, 1'b0, 0);
        no_rsp_for("spi_extra", 5);

        // Reset during WAIT_DONE
        send(3'd4, 32'd0);
        repeat (10) step();
        check("rwait_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rwait_busy0", {31'd0, busy}, 32'd0);
        check("rwait_rdy0", {31'd0, cmd_ready}, 32'd0);
        check("rwait_wav0", spi_wav, 32'd0);
        check("rwait_cfg0", spi_config_lsb, 32'd0);
        step();
        step();
        rst = 1'b1;
        step();
        check("rwait_rdy1", {31'd0, cmd_ready}, 32'd1);
        no_rsp_for("rwait_stale", 60);

        // Reset with a response stalled
        send(3'd6, 32'd1);
        get_rsp_stall: begin
            int n = 0;
            while (rsp_valid !== 1'b1 && n < 50) begin
                step();
                n++;
            end
        end
        check("rrsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rrsp_data", rsp_data, 32'h0000_00A3);
        step();
        #2 rst = 1'b0;
        #1;
        check("rrsp_valid0", {31'd0, rsp_valid}, 32'd0);
        check("rrsp_data0", rsp_data, 32'd0);
        step();
        rst = 1'b1;
        step();
        check("rrsp_rdy1", {31'd0, cmd_ready}, 32'd1);
        no_rsp_for("rrsp_stale", 10);

        // Reserved opcode
        send(3'd7, 32'd0);
        get_rsp("op7", 32'hBAD0_0007, 1'b1, 0);
        wait_ready("op7_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
